// File: rtl/vga_pkg.sv
// Shared definitions for the VGA raster sequencer.
//   mode_t      : one axis of a video mode (active length, sync start, sync end, total)
//   DEF_*_MODE  : 640x480@60 timing loaded at reset
//   mode_valid  : ordering check 0 < width < porch < synch < raw
package vga_pkg;

  typedef struct packed {
    logic [11:0] width;  // active pixels (h) or active lines (v)
    logic [11:0] porch;  // count at which sync becomes active
    logic [11:0] synch;  // count at which sync becomes inactive
    logic [11:0] raw;    // total counts per line (h) or per frame (v)
  } mode_t;

  localparam mode_t DEF_H_MODE = '{width: 12'd640, porch: 12'd656, synch: 12'd752, raw: 12'd800};
  localparam mode_t DEF_V_MODE = '{width: 12'd480, porch: 12'd490, synch: 12'd492, raw: 12'd525};

  // A mode is usable only if its regions are non-empty and strictly ordered;
  // this also guarantees raw >= 4, so raw-1 never underflows.
  function automatic logic mode_valid(input mode_t m);
    mode_valid = (m.width != 12'd0) && (m.width < m.porch) &&
                 (m.porch < m.synch) && (m.synch < m.raw);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping counter plus the shadow mode that governs it.
//   clk, rst_n  : clock, asynchronous active-low reset
//   advance     : step the counter this cycle
//   load        : replace the shadow mode with load_mode this cycle
//   load_mode   : mode to adopt when load is high
//   active_len  : shadow active length (width or height)
//   at_last     : counter sits at raw-1
//   in_active   : counter < width
//   in_sync     : porch <= counter < synch
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter mode_t INIT_MODE = DEF_H_MODE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  input  logic        load,
  input  mode_t       load_mode,
  output logic [11:0] active_len,
  output logic        at_last,
  output logic        in_active,
  output logic        in_sync
);

  logic [11:0] count;
  mode_t       shadow;

  // Position counter, wraps after raw-1 using the mode that was in force for this pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 12'd0;
    end else if (advance) begin
      count <= at_last ? 12'd0 : count + 12'd1;
    end
  end

  // Shadow mode: the only mode the raster ever sees.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= INIT_MODE;
    end else if (load) begin
      shadow <= load_mode;
    end
  end

  assign active_len = shadow.width;
  assign at_last    = (count == shadow.raw - 12'd1);
  assign in_active  = (count < shadow.width);
  assign in_sync    = (count >= shadow.porch) && (count < shadow.synch);

endmodule

// File: rtl/vga_timing_ctrl.sv
// Raster sequencer for the VGA pixel-source path.
// Drives the source's read strobe, line/frame pulses and width/height, and
// produces HSYNC/VSYNC/BLANK delayed to line up with the source's pixel output.
// Requested modes are validated and adopted only at the last clock of a frame.
//   i_pixclk, i_reset_n          : pixel clock, asynchronous active-low reset
//   i_hm_* / i_vm_*              : requested horizontal / vertical mode
//   o_width, o_height            : shadow active size, to the source
//   o_rd, o_newline, o_newframe  : registered raster strobes
//   o_hsync, o_vsync, o_blank    : sync/blank, SYNC_DELAY extra stages
//   o_mode_err                   : sticky, a rejected mode met a frame boundary
// INIT_H_MODE / INIT_V_MODE select the reset mode and must satisfy mode_valid.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned SYNC_DELAY  = 2,
  parameter logic        HSYNC_POL   = 1'b0,
  parameter logic        VSYNC_POL   = 1'b0,
  parameter mode_t       INIT_H_MODE = DEF_H_MODE,
  parameter mode_t       INIT_V_MODE = DEF_V_MODE
) (
  input  logic        i_pixclk,
  input  logic        i_reset_n,
  input  logic [11:0] i_hm_width,
  input  logic [11:0] i_hm_porch,
  input  logic [11:0] i_hm_synch,
  input  logic [11:0] i_hm_raw,
  input  logic [11:0] i_vm_height,
  input  logic [11:0] i_vm_porch,
  input  logic [11:0] i_vm_synch,
  input  logic [11:0] i_vm_raw,
  output logic [11:0] o_width,
  output logic [11:0] o_height,
  output logic        o_rd,
  output logic        o_newline,
  output logic        o_newframe,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_blank,
  output logic        o_mode_err
);

  mode_t req_h;
  mode_t req_v;
  logic  h_last, h_active, h_sync;
  logic  v_last, v_active, v_sync;
  logic  frame_end, mode_ok, load;
  logic  hs_base, vs_base, bl_base;

  assign req_h = '{width: i_hm_width, porch: i_hm_porch, synch: i_hm_synch, raw: i_hm_raw};
  assign req_v = '{width: i_vm_height, porch: i_vm_porch, synch: i_vm_synch, raw: i_vm_raw};

  // h and v are adopted together or not at all, so a frame never mixes modes.
  assign frame_end = h_last && v_last;
  assign mode_ok   = mode_valid(req_h) && mode_valid(req_v);
  assign load      = frame_end && mode_ok;

  vga_axis_counter #(.INIT_MODE(INIT_H_MODE)) u_h (
    .clk        (i_pixclk),
    .rst_n      (i_reset_n),
    .advance    (1'b1),
    .load       (load),
    .load_mode  (req_h),
    .active_len (o_width),
    .at_last    (h_last),
    .in_active  (h_active),
    .in_sync    (h_sync)
  );

  vga_axis_counter #(.INIT_MODE(INIT_V_MODE)) u_v (
    .clk        (i_pixclk),
    .rst_n      (i_reset_n),
    .advance    (h_last),
    .load       (load),
    .load_mode  (req_v),
    .active_len (o_height),
    .at_last    (v_last),
    .in_active  (v_active),
    .in_sync    (v_sync)
  );

  // Sticky rejection flag; only reset clears it.
  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_mode_err <= 1'b0;
    end else if (frame_end && !mode_ok) begin
      o_mode_err <= 1'b1;
    end
  end

  // Raster strobes and undelayed sync/blank, registered from the counter state.
  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_rd       <= 1'b0;
      o_newline  <= 1'b0;
      o_newframe <= 1'b0;
      hs_base    <= ~HSYNC_POL;
      vs_base    <= ~VSYNC_POL;
      bl_base    <= 1'b1;
    end else begin
      o_rd       <= h_active && v_active;
      o_newline  <= h_last;
      o_newframe <= frame_end;
      hs_base    <= h_sync ? HSYNC_POL : ~HSYNC_POL;
      vs_base    <= v_sync ? VSYNC_POL : ~VSYNC_POL;
      bl_base    <= ~(h_active && v_active);
    end
  end

  // Sync/blank delay lines; bit 0 is the newest sample.
  generate
    if (SYNC_DELAY == 32'd0) begin : g_no_delay
      assign o_hsync = hs_base;
      assign o_vsync = vs_base;
      assign o_blank = bl_base;
    end else begin : g_delay
      logic [SYNC_DELAY-1:0] hs_pipe;
      logic [SYNC_DELAY-1:0] vs_pipe;
      logic [SYNC_DELAY-1:0] bl_pipe;

      // Shift the sync/blank samples down the pipe, held inactive in reset.
      always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          hs_pipe <= {SYNC_DELAY{~HSYNC_POL}};
          vs_pipe <= {SYNC_DELAY{~VSYNC_POL}};
          bl_pipe <= {SYNC_DELAY{1'b1}};
        end else begin
          hs_pipe[0] <= hs_base;
          vs_pipe[0] <= vs_base;
          bl_pipe[0] <= bl_base;
          for (int unsigned i = 1; i < SYNC_DELAY; i++) begin
            hs_pipe[i] <= hs_pipe[i-1];
            vs_pipe[i] <= vs_pipe[i-1];
            bl_pipe[i] <= bl_pipe[i-1];
          end
        end
      end

      assign o_hsync = hs_pipe[SYNC_DELAY-1];
      assign o_vsync = vs_pipe[SYNC_DELAY-1];
      assign o_blank = bl_pipe[SYNC_DELAY-1];
    end
  endgenerate

endmodule
